// File: rtl/dw_fifoctl_mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : dw_fifoctl_mc_pkg
//  Brief   : Shared constants and width helpers for the multi-channel FIFO
//            controller (optional feature macro: FIFOCTL_MC_WATERMARK_EN).
//  Revision: 1.0
// ============================================================================
package dw_fifoctl_mc_pkg;

    localparam int ERR_STICKY = 0;
    localparam int ERR_PULSE  = 1;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int aw_of(input int depth);
        return clog2(depth);
    endfunction

    function automatic int cw_of(input int channels);
        return (channels > 1) ? clog2(channels) : 1;
    endfunction

    function automatic int nw_of(input int depth);
        return clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dw_fifoctl_mc_chan.sv
`default_nettype none
// ============================================================================
//  Module  : dw_fifoctl_mc_chan
//  Brief   : Pointers, word count, status flags and error for one logical FIFO.
//            FIFOCTL_MC_WATERMARK_EN adds a peak word-count register.
//  Revision: 1.0
// ============================================================================
module dw_fifoctl_mc_chan
    import dw_fifoctl_mc_pkg::*;
#(
    parameter int depth    = 8,
    parameter int err_mode = ERR_STICKY
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     init_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     offence,
    input  logic [nw_of(depth)-1:0]  ae_level,
    input  logic [nw_of(depth)-1:0]  af_level,
    output logic [aw_of(depth)-1:0]  wr_ptr,
    output logic [aw_of(depth)-1:0]  rd_ptr,
    output logic [nw_of(depth)-1:0]  count,
    output logic                     empty,
    output logic                     almost_empty,
    output logic                     half_full,
    output logic                     almost_full,
    output logic                     full,
    output logic                     error
`ifdef FIFOCTL_MC_WATERMARK_EN
    ,
    output logic [nw_of(depth)-1:0]  peak
`endif
);

    localparam int               c_AW    = aw_of(depth);
    localparam int               c_NW    = nw_of(depth);
    localparam logic [c_NW-1:0]  c_DEPTH = c_NW'(depth);
    localparam logic [c_NW-1:0]  c_HALF  = c_NW'((depth + 1) / 2);

    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_NW-1:0] r_count;
    logic            r_error;
    logic [c_NW-1:0] w_count_nxt;

    always_comb begin
        w_count_nxt = r_count;
        case ({push, pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_error  <= 1'b0;
        end else if (!init_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_error  <= 1'b0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_error <= (err_mode == ERR_PULSE) ? offence : (r_error | offence);
        end
    end

`ifdef FIFOCTL_MC_WATERMARK_EN
    logic [c_NW-1:0] r_peak;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_peak <= '0;
        end else if (!init_n) begin
            r_peak <= '0;
        end else if (w_count_nxt > r_peak) begin
            r_peak <= w_count_nxt;
        end
    end

    assign peak = r_peak;
`endif

    assign wr_ptr       = r_wr_ptr;
    assign rd_ptr       = r_rd_ptr;
    assign count        = r_count;
    assign error        = r_error;
    assign empty        = (r_count == '0);
    assign full         = (r_count == c_DEPTH);
    assign almost_empty = (r_count <= ae_level);
    assign half_full    = (r_count >= c_HALF);
    // count >= depth - af_level, rearranged so a large af_level cannot go negative.
    assign almost_full  = (({1'b0, r_count} + {1'b0, af_level}) >= {1'b0, c_DEPTH});

endmodule
`default_nettype wire

// File: rtl/dw_fifoctl_s1_mc.sv
`default_nettype none
// ============================================================================
//  Module  : dw_fifoctl_s1_mc
//  Brief   : Single-clock multi-channel FIFO controller over a shared 1W1R RAM.
//            FIFOCTL_MC_WATERMARK_EN adds the per-channel peak_count output.
//  Revision: 1.0
// ============================================================================
module dw_fifoctl_s1_mc
    import dw_fifoctl_mc_pkg::*;
#(
    parameter int depth    = 8,
    parameter int channels = 4,
    parameter int err_mode = ERR_STICKY
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        init_n,
    input  logic                                        push_req_n,
    input  logic [cw_of(channels)-1:0]                  push_ch,
    input  logic                                        pop_req_n,
    input  logic [cw_of(channels)-1:0]                  pop_ch,
    input  logic [nw_of(depth)-1:0]                     ae_level,
    input  logic [nw_of(depth)-1:0]                     af_level,
    output logic                                        we_n,
    output logic [cw_of(channels)+aw_of(depth)-1:0]     wr_addr,
    output logic [cw_of(channels)+aw_of(depth)-1:0]     rd_addr,
    output logic [channels-1:0]                         empty,
    output logic [channels-1:0]                         almost_empty,
    output logic [channels-1:0]                         half_full,
    output logic [channels-1:0]                         almost_full,
    output logic [channels-1:0]                         full,
    output logic [channels-1:0]                         error,
    output logic [channels*nw_of(depth)-1:0]            word_count
`ifdef FIFOCTL_MC_WATERMARK_EN
    ,
    output logic [channels*nw_of(depth)-1:0]            peak_count
`endif
);

    localparam int c_AW = aw_of(depth);
    localparam int c_CW = cw_of(channels);
    localparam int c_NW = nw_of(depth);

    logic [channels-1:0] w_push_hit;
    logic [channels-1:0] w_pop_hit;
    logic [c_AW-1:0]     w_wr_ptr [channels];
    logic [c_AW-1:0]     w_rd_ptr [channels];
    logic [c_AW-1:0]     w_wr_sel;
    logic [c_AW-1:0]     w_rd_sel;
    logic                w_push_req;
    logic                w_pop_req;
    logic                w_push_full;
    logic                w_pop_empty;
    logic                w_same_ch;
    logic                w_push_ok;
    logic                w_pop_ok;

    genvar c;
    generate
        for (c = 0; c < channels; c++) begin : g_dec
            assign w_push_hit[c] = (channels == 1) || (push_ch == c_CW'(c));
            assign w_pop_hit[c]  = (channels == 1) || (pop_ch == c_CW'(c));
        end
    endgenerate

    assign w_push_req  = !push_req_n && init_n;
    assign w_pop_req   = !pop_req_n && init_n;
    assign w_push_full = |(full & w_push_hit);
    assign w_pop_empty = |(empty & w_pop_hit);
    assign w_same_ch   = (channels == 1) || (push_ch == pop_ch);

    // A same-cycle push never rescues an empty channel, but a pop frees a full one.
    assign w_pop_ok  = w_pop_req && !w_pop_empty;
    assign w_push_ok = w_push_req && (!w_push_full || (w_pop_ok && w_same_ch));
    assign we_n      = !w_push_ok;

    always_comb begin
        w_wr_sel = '0;
        w_rd_sel = '0;
        for (int i = 0; i < channels; i++) begin
            if (w_push_hit[i]) w_wr_sel = w_wr_ptr[i];
            if (w_pop_hit[i])  w_rd_sel = w_rd_ptr[i];
        end
    end

    assign wr_addr = {push_ch, w_wr_sel};
    assign rd_addr = {pop_ch, w_rd_sel};

    generate
        for (c = 0; c < channels; c++) begin : g_chan
            dw_fifoctl_mc_chan #(
                .depth    (depth),
                .err_mode (err_mode)
            ) u_chan (
                .clk          (clk),
                .rst_n        (rst_n),
                .init_n       (init_n),
                .push         (w_push_ok && w_push_hit[c]),
                .pop          (w_pop_ok && w_pop_hit[c]),
                .offence      ((w_push_req && !w_push_ok && w_push_hit[c]) ||
                               (w_pop_req && !w_pop_ok && w_pop_hit[c])),
                .ae_level     (ae_level),
                .af_level     (af_level),
                .wr_ptr       (w_wr_ptr[c]),
                .rd_ptr       (w_rd_ptr[c]),
                .count        (word_count[c*c_NW +: c_NW]),
                .empty        (empty[c]),
                .almost_empty (almost_empty[c]),
                .half_full    (half_full[c]),
                .almost_full  (almost_full[c]),
                .full         (full[c]),
                .error        (error[c])
`ifdef FIFOCTL_MC_WATERMARK_EN
                ,
                .peak         (peak_count[c*c_NW +: c_NW])
`endif
            );
        end
    endgenerate

endmodule
`default_nettype wire
